riscv_div32: RTL and testbench
==============================

RISCV_DIV32 -- requirements
Module: riscv_div32

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand and result width in bits; legal values are even and at least 4.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: the reset, synchronous and active-high.
REQ-004 The block SHALL have port in_valid, input, 1 bit: an operation is offered.
REQ-005 The block SHALL have port in_ready, output, 1 bit: the block can accept an operation.
REQ-006 The block SHALL have port srca, input, WIDTH bits: the dividend.
REQ-007 The block SHALL have port srcb, input, WIDTH bits: the divisor.
REQ-008 The block SHALL have port divop, input, 2 bits, encoded 00 DIV, 01 DIVU, 10 REM, 11 REMU.
REQ-009 The block SHALL have port out_valid, output, 1 bit: result is valid.
REQ-010 The block SHALL have port out_ready, input, 1 bit: the consumer accepts the result.
REQ-011 The block SHALL have port result, output, WIDTH bits: quotient (DIV/DIVU) or remainder (REM/REMU).
REQ-012 The block SHALL have port busy, output, 1 bit: high in every state except IDLE.

Function
REQ-013 The block SHALL implement three states: IDLE, CALC, DONE.
REQ-014 In IDLE the block SHALL drive in_ready=1; in CALC and DONE it SHALL drive in_ready=0.
REQ-015 Acceptance SHALL occur when in_valid=1 and in_ready=1; at acceptance srca, srcb and divop are captured and the state moves to CALC.
REQ-016 Operand changes after acceptance SHALL NOT affect the result.
REQ-017 The capture step SHALL convert signed operands (DIV/REM) to magnitudes and record the quotient sign (sa^sb) and the remainder sign (sa).
REQ-018 CALC SHALL perform restoring division at one quotient bit per cycle, running for exactly WIDTH cycles counted by a 0..WIDTH-1 counter, then move to DONE.
REQ-019 On entry to DONE the block SHALL apply the sign fixes, register result and assert out_valid; out_valid first rises WIDTH+1 cycles after the acceptance edge.
REQ-020 Result rules (two's complement, modulo 2^WIDTH): signed quotient truncates toward zero; the remainder takes the sign of the dividend.
REQ-021 Divide-by-zero SHALL give a quotient of all ones (DIV and DIVU) and a remainder equal to the original dividend (REM and REMU).
REQ-022 Signed overflow (dividend = most-negative value, divisor = -1) SHALL give a quotient equal to the dividend and a remainder of 0.
REQ-023 In DONE, result and out_valid SHALL hold stable until out_ready=1; on that edge the block SHALL drop out_valid and return to IDLE.
REQ-024 A new operation SHALL NOT be accepted in the same cycle as the output handshake; the earliest acceptance is the following cycle.
REQ-025 in_valid while not in IDLE SHALL be ignored.
REQ-026 Invalid or unknown states SHALL recover to IDLE.

Reset
REQ-027 With reset=1 at a clock edge, the block SHALL enter IDLE, with out_valid=0, busy=0, in_ready=1, result=0 and the counter at 0.
REQ-028 Reset SHALL take precedence over all other inputs and SHALL abort any operation in CALC or DONE without producing a result.

Configuration
REQ-029 The block SHALL support the macro DIV_EARLY_OUT_EN.
REQ-030 With DIV_EARLY_OUT_EN defined, divide-by-zero and signed overflow operations SHALL bypass CALC: IDLE moves to DONE, and out_valid rises 1 cycle after acceptance.
REQ-031 Without DIV_EARLY_OUT_EN, all operations SHALL take WIDTH+1 cycles.
REQ-032 Result values SHALL be identical with and without DIV_EARLY_OUT_EN.

Verification
REQ-033 A DIVU test SHALL apply 100/7 and require result 14 at cycle 33, then REMU 100/7 and require result 2; out_ready is held at 1.
REQ-034 A signed test SHALL apply DIV -7/2 and require 0xFFFFFFFD, then REM -7/2 and require 0xFFFFFFFF; REM 7/-2 SHALL give 1.
REQ-035 An overflow test SHALL apply DIV 0x80000000 / 0xFFFFFFFF and require 0x80000000; REM SHALL give 0; latency is 1 cycle with DIV_EARLY_OUT_EN and 33 without.
REQ-036 A divide-by-zero test SHALL apply DIVU 5/0 and require 0xFFFFFFFF, then REMU 5/0 and require 5; DIV -3/0 SHALL give 0xFFFFFFFF.
REQ-037 A backpressure test SHALL hold out_ready=0 for 5 cycles in DONE and require result stable, out_valid=1 and in_ready=0; in_valid pulsed during CALC SHALL be ignored.
REQ-038 A reset test SHALL assert reset at CALC cycle 10 and require out_valid=0, in_ready=1 and busy=0 the next cycle, with no result emitted afterwards.

Source files
------------

// File: rtl/riscv_div32.sv
// riscv_div32: multi-cycle RISC-V DIV/DIVU/REM/REMU unit using restoring
// division, one quotient bit per clock.
// Optional macro DIV_EARLY_OUT_EN: divide-by-zero and signed overflow skip
// the iterative phase and finish one cycle after acceptance.
//
// Handshake: an operation is accepted on a rising edge where
// in_valid && in_ready. A result is consumed on a rising edge where
// out_valid && out_ready. result is stable while out_valid is high.
// Nothing is accepted on the edge that consumes a result.
module riscv_div32 #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] srca,
  input  logic [WIDTH-1:0] srcb,
  input  logic [1:0]       divop,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             busy,
  output logic [1:0]       dbg_state
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0]    LAST     = CW'(WIDTH - 1);
  localparam logic [CW-1:0]    ONE_CNT  = CW'(1);
  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, next_state;

  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] quot_r;   // dividend magnitude shifting out, quotient shifting in
  logic [WIDTH-1:0] rem_r;    // partial remainder
  logic [WIDTH-1:0] dvsr_r;   // divisor magnitude
  logic [WIDTH-1:0] orig_a;   // original dividend, for div-by-zero and overflow results
  logic             op_rem;
  logic             neg_q;
  logic             neg_r;
  logic             div0;
  logic             ovf;

  // Operand decode, used only on the acceptance edge
  logic             in_signed, in_sa, in_sb, in_div0, in_ovf, early;
  logic [WIDTH-1:0] in_amag, in_bmag;

  assign in_signed = ~divop[0];
  assign in_sa     = in_signed & srca[WIDTH-1];
  assign in_sb     = in_signed & srcb[WIDTH-1];
  assign in_amag   = in_sa ? (~srca + ONE) : srca;
  assign in_bmag   = in_sb ? (~srcb + ONE) : srcb;
  assign in_div0   = (srcb == '0);
  assign in_ovf    = in_signed & (srca == MOST_NEG) & (srcb == '1);

`ifdef DIV_EARLY_OUT_EN
  assign early = in_div0 | in_ovf;
`else
  assign early = 1'b0;
`endif

  // One restoring step: shift in the next dividend bit, trial-subtract
  logic [WIDTH:0] shifted, diff;
  assign shifted = {rem_r, quot_r[WIDTH-1]};
  assign diff    = shifted - {1'b0, dvsr_r};

  // Sign fixes and special-case selection applied on entry to DONE
  logic [WIDTH-1:0] q_fix, r_fix, final_res;
  assign q_fix = neg_q ? (~quot_r + ONE) : quot_r;
  assign r_fix = neg_r ? (~rem_r + ONE) : rem_r;
  assign final_res = op_rem ? (div0 ? orig_a : (ovf ? '0 : r_fix))
                            : (div0 ? '1     : (ovf ? orig_a : q_fix));

  assign dbg_state = state;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Next-state and handshake outputs
  always_comb begin
    next_state = state;
    in_ready   = 1'b0;
    busy       = 1'b1;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) next_state = early ? DONE : CALC;
      end
      CALC: if (cnt == LAST) next_state = DONE;
      DONE: if (out_valid && out_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Datapath: capture, iterate, finalize and hold the result
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt       <= '0;
      quot_r    <= '0;
      rem_r     <= '0;
      dvsr_r    <= '0;
      orig_a    <= '0;
      op_rem    <= 1'b0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      div0      <= 1'b0;
      ovf       <= 1'b0;
      result    <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          cnt <= '0;
          if (in_valid) begin
            quot_r <= in_amag;
            rem_r  <= '0;
            dvsr_r <= in_bmag;
            orig_a <= srca;
            op_rem <= divop[1];
            neg_q  <= in_sa ^ in_sb;
            neg_r  <= in_sa;
            div0   <= in_div0;
            ovf    <= in_ovf;
          end
        end
        CALC: begin
          cnt <= (cnt == LAST) ? '0 : cnt + ONE_CNT;
          if (!diff[WIDTH]) begin
            rem_r  <= diff[WIDTH-1:0];
            quot_r <= {quot_r[WIDTH-2:0], 1'b1};
          end else begin
            rem_r  <= shifted[WIDTH-1:0];
            quot_r <= {quot_r[WIDTH-2:0], 1'b0};
          end
        end
        DONE: begin
          if (!out_valid) begin
            result    <= final_res;
            out_valid <= 1'b1;
          end else if (out_ready) begin
            out_valid <= 1'b0;
          end
        end
        default: out_valid <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_riscv_div32.sv
// Testbench for riscv_div32: directed vector table, randomized operations
// against an arithmetic reference model, backpressure and reset sequences.
module tb_riscv_div32;

  localparam int W = 32;
  localparam int NORMAL_LAT = W + 1;
`ifdef DIV_EARLY_OUT_EN
  localparam int SPECIAL_LAT = 1;
`else
  localparam int SPECIAL_LAT = W + 1;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] srca, srcb;
  logic [1:0]   divop;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         busy;
  logic [1:0]   dbg_state;

  int tests = 0;
  int fails = 0;
  logic [W-1:0] exp_q[$];

  riscv_div32 #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .srca(srca), .srcb(srcb), .divop(divop),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .busy(busy), .dbg_state(dbg_state)
  );

  // Clock
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [1:0]   op;
    logic [W-1:0] exp;
    int           lat;
  } vec_t;

  vec_t vecs[15];

  // Reference model: RISC-V M-extension division rules in plain arithmetic
  function automatic logic [W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic [1:0] op);
    int sa;
    int sb;
    if (b == '0) return op[1] ? a : '1;
    if (!op[0]) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return op[1] ? '0 : a;
      sa = a;
      sb = b;
      return op[1] ? (sa % sb) : (sa / sb);
    end
    return op[1] ? (a % b) : (a / b);
  endfunction

  function automatic bit is_special(input logic [W-1:0] a, input logic [W-1:0] b,
                                    input logic [1:0] op);
    return (b == '0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Drive one operation with out_ready held by the caller; checks latency and value
  task automatic run_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [1:0] op, input int exp_lat);
    int lat;
    int wait_cyc;
    wait_cyc = 0;
    while (!in_ready && wait_cyc < 200) begin
      @(posedge clk); #1;
      wait_cyc++;
    end
    if (!in_ready) begin
      tests++;
      fails++;
      $display("FAIL %s_ready: in_ready stuck at 0, expected 1", name);
      return;
    end
    exp_q.push_back(model(a, b, op));
    in_valid = 1'b1; srca = a; srcb = b; divop = op;
    @(posedge clk); #1;
    in_valid = 1'b0;
    srca = $urandom; srcb = $urandom; divop = 2'($urandom_range(0, 3));
    lat = 0;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    check({name, "_lat"}, W'(lat), W'(exp_lat));
    check(name, result, exp_q.pop_front());
  endtask

  initial begin
    int lat;
    bit stray;
    logic [W-1:0] a, b;
    logic [1:0] op;
    int r;

    vecs[0]  = '{32'd100,       32'd7,         2'b01, 32'd14,        NORMAL_LAT};
    vecs[1]  = '{32'd100,       32'd7,         2'b11, 32'd2,         NORMAL_LAT};
    vecs[2]  = '{32'hFFFF_FFF9, 32'd2,         2'b00, 32'hFFFF_FFFD, NORMAL_LAT};
    vecs[3]  = '{32'hFFFF_FFF9, 32'd2,         2'b10, 32'hFFFF_FFFF, NORMAL_LAT};
    vecs[4]  = '{32'd7,         32'hFFFF_FFFE, 2'b10, 32'd1,         NORMAL_LAT};
    vecs[5]  = '{32'h8000_0000, 32'hFFFF_FFFF, 2'b00, 32'h8000_0000, SPECIAL_LAT};
    vecs[6]  = '{32'h8000_0000, 32'hFFFF_FFFF, 2'b10, 32'd0,         SPECIAL_LAT};
    vecs[7]  = '{32'd5,         32'd0,         2'b01, 32'hFFFF_FFFF, SPECIAL_LAT};
    vecs[8]  = '{32'd5,         32'd0,         2'b11, 32'd5,         SPECIAL_LAT};
    vecs[9]  = '{32'hFFFF_FFFD, 32'd0,         2'b00, 32'hFFFF_FFFF, SPECIAL_LAT};
    vecs[10] = '{32'hFFFF_FFFD, 32'd0,         2'b10, 32'hFFFF_FFFD, SPECIAL_LAT};
    vecs[11] = '{32'h8000_0000, 32'hFFFF_FFFF, 2'b01, 32'd0,         NORMAL_LAT};
    vecs[12] = '{32'hFFFF_FFFF, 32'd1,         2'b01, 32'hFFFF_FFFF, NORMAL_LAT};
    vecs[13] = '{32'd7,         32'hFFFF_FFFE, 2'b00, 32'hFFFF_FFFD, NORMAL_LAT};
    vecs[14] = '{32'h8000_0000, 32'd2,         2'b00, 32'hC000_0000, NORMAL_LAT};

    // Reset
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    srca = '0; srcb = '0; divop = 2'b00;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", W'(out_valid), 0);
    check("rst_in_ready",  W'(in_ready), 1);
    check("rst_busy",      W'(busy), 0);
    check("rst_result",    result, 0);
    check("rst_state",     W'(dbg_state), 0);
    reset = 1'b0;

    // Directed vector table (the table values are hand-derived)
    for (int i = 0; i < 15; i++) begin
      tests++;
      if (model(vecs[i].a, vecs[i].b, vecs[i].op) !== vecs[i].exp) begin
        fails++;
        $display("FAIL model_vec%0d: got 0x%08h, expected 0x%08h", i,
                 model(vecs[i].a, vecs[i].b, vecs[i].op), vecs[i].exp);
      end
      run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].lat);
    end

    // Randomized operations against the model
    for (int i = 0; i < 40; i++) begin
      op = 2'($urandom_range(0, 3));
      a  = $urandom;
      r  = $urandom_range(0, 9);
      if (r == 0)      b = '0;
      else if (r == 1) begin
        b = '1;
        if ($urandom_range(0, 1) == 1) a = 32'h8000_0000;
      end
      else if (r <= 4) b = W'($urandom_range(1, 15));
      else             b = $urandom;
      run_op($sformatf("rand%0d", i), a, b, op,
             is_special(a, b, op) ? SPECIAL_LAT : NORMAL_LAT);
    end

    // Backpressure with an in_valid pulse during CALC
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid = 1'b1; srca = 32'd1000; srcb = 32'd9; divop = 2'b01;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    in_valid = 1'b1; srca = 32'd3; srcb = 32'd1; divop = 2'b01;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("bp_calc_busy", W'(busy), 1);
    check("bp_calc_in_ready", W'(in_ready), 0);
    lat = 0;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    check("bp_result", result, 32'd111);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      check($sformatf("bp_hold_result%0d", k), result, 32'd111);
      check($sformatf("bp_hold_valid%0d", k), W'(out_valid), 1);
      check($sformatf("bp_hold_in_ready%0d", k), W'(in_ready), 0);
    end
    // in_valid held across the output handshake: accepted one edge later
    in_valid = 1'b1; srca = 32'd20; srcb = 32'd4; divop = 2'b01;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("hs_out_valid_drop", W'(out_valid), 0);
    check("hs_in_ready", W'(in_ready), 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("hs_accept_busy", W'(busy), 1);
    lat = 0;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    check("hs_lat", W'(lat), W'(NORMAL_LAT));
    check("hs_result", result, 32'd5);

    // Reset in the middle of CALC
    @(posedge clk); #1;
    in_valid = 1'b1; srca = 32'd100; srcb = 32'd7; divop = 2'b01;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("mid_busy", W'(busy), 1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("mid_rst_out_valid", W'(out_valid), 0);
    check("mid_rst_in_ready", W'(in_ready), 1);
    check("mid_rst_busy", W'(busy), 0);
    check("mid_rst_result", result, 0);
    stray = 1'b0;
    repeat (50) begin
      @(posedge clk); #1;
      if (out_valid) stray = 1'b1;
    end
    check("mid_rst_no_result", W'(stray), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
